// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcodes, instruction formats, field slot positions
// and the opcode-to-format map used by both the decoder and the loader.
package cpu_isa_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0001;
    localparam logic [3:0] OP_ITYPE = 4'b0010;
    localparam logic [3:0] OP_JMP   = 4'b0011;
    localparam logic [3:0] OP_BR    = 4'b0100;
    localparam logic [3:0] OP_LD    = 4'b0101;
    localparam logic [3:0] OP_ST    = 4'b0110;
    localparam logic [3:0] OP_CALL  = 4'b0111;
    localparam logic [3:0] OP_RET   = 4'b1000;
    localparam logic [3:0] OP_1001  = 4'b1001;
    localparam logic [3:0] OP_1010  = 4'b1010;
    localparam logic [3:0] OP_1011  = 4'b1011;

    typedef enum logic [1:0] {
        FMT_R = 2'b00,
        FMT_I = 2'b01,
        FMT_J = 2'b10,
        FMT_B = 2'b11
    } fmt_e;

    // Nibble slots of the 16-bit word, most significant first.
    localparam int F_OP_LSB = 12;
    localparam int F_A_LSB  = 8;
    localparam int F_B_LSB  = 4;
    localparam int F_C_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_LAST = 2'b10,
        ST_DONE = 2'b11
    } ld_state_e;

    function automatic fmt_e fmt_of(input logic [3:0] op);
        fmt_e f;
        case (op)
            OP_ITYPE:                f = FMT_I;
            OP_JMP, OP_CALL, OP_RET: f = FMT_J;
            OP_BR:                   f = FMT_B;
            default:                 f = FMT_R;
        endcase
        return f;
    endfunction

    function automatic logic op_listed(input logic [3:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_ITYPE, OP_JMP, OP_BR, OP_LD, OP_ST,
            OP_CALL, OP_RET, OP_1001, OP_1010, OP_1011: ok = 1'b1;
            default:                                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: selects the format from the opcode and assembles the
// 16-bit instruction word; unlisted opcodes are packed as R format.
module instr_field_pack
    import cpu_isa_pkg::*;
(
    input  logic [3:0]  opcode_i,
    input  logic [3:0]  rd_i,
    input  logic [3:0]  rs1_i,
    input  logic [3:0]  rs2_i,
    input  logic [11:0] imm_i,
    output logic [15:0] word_o,
    output logic [1:0]  fmt_o,
    output logic        illegal_o
);

    fmt_e fmt;

    always_comb begin
        fmt    = fmt_of(opcode_i);
        word_o = '0;
        word_o[F_OP_LSB +: 4] = opcode_i;
        case (fmt)
            FMT_I: begin
                word_o[F_A_LSB +: 4] = rd_i;
                word_o[F_B_LSB +: 4] = rs1_i;
                word_o[F_C_LSB +: 4] = imm_i[3:0];
            end
            FMT_J: begin
                word_o[F_C_LSB +: 12] = imm_i;
            end
            FMT_B: begin
                word_o[F_A_LSB +: 4] = rs1_i;
                word_o[F_B_LSB +: 4] = rs2_i;
                word_o[F_C_LSB +: 4] = imm_i[3:0];
            end
            default: begin
                word_o[F_A_LSB +: 4] = rd_i;
                word_o[F_B_LSB +: 4] = rs1_i;
                word_o[F_C_LSB +: 4] = rs2_i;
            end
        endcase
        fmt_o     = fmt;
        illegal_o = ~op_listed(opcode_i);
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Program/boot loader: packs streamed instruction fields and writes them to
// consecutive imem addresses. Define ENCODE_OPCODE_CHECK_EN for the sticky err flag.
module instr_encode_loader
    import cpu_isa_pkg::*;
#(
    parameter int IW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   num_instr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_opcode,
    input  logic [3:0]    in_rd,
    input  logic [3:0]    in_rs1,
    input  logic [3:0]    in_rs2,
    input  logic [11:0]   in_imm,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [IW-1:0] imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   REM_ONE = 1;

    ld_state_e     state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   rem_q, rem_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] wdata_q, wdata_d;
    logic [15:0]   pack_word;
    logic [1:0]    pack_fmt_unused;
    logic          hs;
`ifdef ENCODE_OPCODE_CHECK_EN
    logic          pack_illegal;
`else
    logic          pack_illegal_unused;
`endif

    instr_field_pack u_pack (
        .opcode_i  (in_opcode),
        .rd_i      (in_rd),
        .rs1_i     (in_rs1),
        .rs2_i     (in_rs2),
        .imm_i     (in_imm),
        .word_o    (pack_word),
        .fmt_o     (pack_fmt_unused),
`ifdef ENCODE_OPCODE_CHECK_EN
        .illegal_o (pack_illegal)
`else
        .illegal_o (pack_illegal_unused)
`endif
    );

    assign hs = in_valid && (state_q == ST_LOAD);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        in_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d   = base_addr;
                    rem_d   = num_instr;
                    state_d = (num_instr != '0) ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (hs) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = pack_word;
                    ptr_d   = ptr_q + PTR_ONE;
                    rem_d   = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) state_d = ST_LAST;
                end
            end
            // The final write registered in LOAD is on the outputs here.
            ST_LAST: state_d = ST_DONE;
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q != ST_IDLE);

`ifdef ENCODE_OPCODE_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && start) err_d = 1'b0;
        else if (hs && pack_illegal)     err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
